// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the CPU/DMA data-memory arbiter.
package mem_arb_pkg;

  localparam int unsigned STARVE_MAX_DEF = 4;
  localparam int unsigned WAIT_W         = 4;
  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned DATA_W         = 32;

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    DMA_ACC = 2'd1,
    DMA_ACK = 2'd2
  } arb_state_e;

  // One memory-port access as presented to the data memory.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              wr;
  } mem_req_t;

endpackage

// File: rtl/arb_wait_cnt.sv
// Saturating count of cycles the DMA has waited behind the CPU.
module arb_wait_cnt
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              clr,
  output logic [WAIT_W-1:0] cnt
);

  localparam logic [WAIT_W-1:0] CNT_MAX = '1;

  // Clear has priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + WAIT_W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port data-memory arbiter: CPU has priority, DMA is forced in after
// STARVE_MAX consecutive lost cycles.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CMP_W = WAIT_W + 1;

  arb_state_e        state;
  arb_state_e        state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CMP_W-1:0]  wait_next;
  logic              starve_hit;
  logic              cnt_inc;
  logic              cnt_clr;
  logic              cpu_own;
  logic              dma_own;
  mem_req_t          mem_req;

  arb_wait_cnt u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .cnt   (wait_cnt)
  );

  assign wait_next  = {1'b0, wait_cnt} + CMP_W'(1);
  assign starve_hit = (wait_next >= CMP_W'(STARVE_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= NORMAL;
    end else begin
      state <= state_next;
    end
  end

  // Next state, port ownership and counter control.
  always_comb begin
    state_next = state;
    cnt_inc    = 1'b0;
    cnt_clr    = ~dma_req;
    cpu_own    = 1'b0;
    dma_own    = 1'b0;
    cpu_stall  = 1'b0;
    unique case (state)
      NORMAL: begin
        cpu_own = cpu_req;
        if (dma_req) begin
          if (!cpu_req || starve_hit) begin
            state_next = DMA_ACC;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      DMA_ACC: begin
        dma_own    = 1'b1;
        cpu_stall  = cpu_req;
        state_next = DMA_ACK;
      end
      DMA_ACK: begin
        cpu_own    = cpu_req;
        state_next = NORMAL;
      end
      default: state_next = NORMAL;
    endcase
    if (state_next == DMA_ACC) begin
      cnt_clr = 1'b1;
    end
    // The port is idle while reset is held, whatever the requesters drive.
    if (!rst_n) begin
      cpu_own   = 1'b0;
      dma_own   = 1'b0;
      cpu_stall = 1'b0;
    end
  end

  always_comb begin
    mem_req = '0;
    if (cpu_own) begin
      mem_req.addr  = cpu_addr;
      mem_req.wdata = cpu_wdata;
      mem_req.wr    = cpu_we;
    end else if (dma_own) begin
      mem_req.addr  = dma_addr;
      mem_req.wdata = dma_wdata;
      mem_req.wr    = dma_we;
    end
  end

  assign mem_addr  = mem_req.addr;
  assign mem_wdata = mem_req.wdata;
  assign mem_wr    = mem_req.wr;
  assign cpu_rdata = cpu_own ? mem_rdata : '0;

  // Ack pulses in the DMA_ACK cycle; load data captured at the end of DMA_ACC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dma_ack   <= 1'b0;
      dma_rdata <= '0;
    end else begin
      dma_ack <= (state == DMA_ACC);
      if ((state == DMA_ACC) && !dma_we) begin
        dma_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small word-addressed data memory.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        dma_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_wr;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mem [0:15] = '{
    32'h0000_0100, 32'h0000_0101, 32'h0000_0102, 32'h0000_0103,
    32'hCAFE_BABE, 32'h0000_0105, 32'h0000_0106, 32'h0000_0107,
    32'h0000_0108, 32'h0000_0109, 32'h0000_010A, 32'h0000_010B,
    32'h0000_010C, 32'h0000_010D, 32'h0000_010E, 32'h0000_010F
  };

  always #5 clk = ~clk;

  // Data memory: combinational read, write on the falling edge.
  assign mem_rdata = mem[mem_addr[5:2]];
  always @(negedge clk) begin
    if (mem_wr) mem[mem_addr[5:2]] <= mem_wdata;
  end

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_ack   (dma_ack),
    .dma_rdata (dma_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wr    (mem_wr),
    .mem_rdata (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_drive(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
    cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
  endtask

  task automatic dma_drive(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
    dma_req = req; dma_we = we; dma_addr = addr; dma_wdata = wdata;
  endtask

  initial begin
    rst_n = 1'b0;
    cpu_drive(1'b1, 1'b1, 32'h8, 32'hDEAD_BEEF);
    dma_drive(1'b1, 1'b1, 32'h0, 32'h0);
    #2;
    chk("rst_mem_wr", mem_wr, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_stall", cpu_stall, 1'b0);
    chk("rst_ack", dma_ack, 1'b0);
    chk("rst_rdata", dma_rdata, 32'h0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
    dma_drive(1'b0, 1'b0, 32'h0, 32'h0);
    cyc();
    chk("rst_no_write", mem[2], 32'h0000_0102);

    // DMA-only load of M[4]
    dma_drive(1'b1, 1'b0, 32'h10, 32'h0);
    #1;
    chk("dl_idle_addr", mem_addr, 32'h0);
    chk("dl_idle_wr", mem_wr, 1'b0);
    cyc();
    chk("dl_acc_addr", mem_addr, 32'h10);
    chk("dl_acc_stall", cpu_stall, 1'b0);
    chk("dl_acc_ack", dma_ack, 1'b0);
    cyc();
    chk("dl_ack", dma_ack, 1'b1);
    chk("dl_rdata", dma_rdata, 32'hCAFE_BABE);
    cyc();
    dma_drive(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("dl_ack_drop", dma_ack, 1'b0);

    // Contention: CPU reads M[4] four times, then DMA reads M[1]
    cpu_drive(1'b1, 1'b0, 32'h10, 32'h0);
    dma_drive(1'b1, 1'b0, 32'h4, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("ct_stall%0d", i), cpu_stall, 1'b0);
      chk($sformatf("ct_rdata%0d", i), cpu_rdata, 32'hCAFE_BABE);
      cyc();
    end
    #1;
    chk("ct_acc_stall", cpu_stall, 1'b1);
    chk("ct_acc_addr", mem_addr, 32'h4);
    chk("ct_acc_ack", dma_ack, 1'b0);
    cyc();
    // CPU store to M[2] in the ack cycle while dma_req is still high
    cpu_drive(1'b1, 1'b1, 32'h8, 32'h1234_5678);
    #1;
    chk("ct_ack", dma_ack, 1'b1);
    chk("ct_ack_stall", cpu_stall, 1'b0);
    chk("ct_dma_rdata", dma_rdata, 32'h0000_0101);
    chk("st_addr", mem_addr, 32'h8);
    chk("st_wdata", mem_wdata, 32'h1234_5678);
    chk("st_wr", mem_wr, 1'b1);
    cyc();
    cpu_drive(1'b1, 1'b0, 32'h8, 32'h0);
    dma_drive(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("st_mem", mem[2], 32'h1234_5678);
    chk("st_readback", cpu_rdata, 32'h1234_5678);
    chk("st_no_reacc", cpu_stall, 1'b0);
    chk("st_ack_drop", dma_ack, 1'b0);
    cyc();

    // DMA write of M[7]
    cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
    dma_drive(1'b1, 1'b1, 32'h1C, 32'hA5A5_A5A5);
    #1;
    chk("dw_idle_wr", mem_wr, 1'b0);
    cyc();
    chk("dw_acc_wr", mem_wr, 1'b1);
    chk("dw_acc_addr", mem_addr, 32'h1C);
    chk("dw_acc_wdata", mem_wdata, 32'hA5A5_A5A5);
    cyc();
    chk("dw_ack", dma_ack, 1'b1);
    chk("dw_rdata_kept", dma_rdata, 32'h0000_0101);
    chk("dw_mem", mem[7], 32'hA5A5_A5A5);
    cyc();
    dma_drive(1'b0, 1'b0, 32'h0, 32'h0);
    cpu_drive(1'b1, 1'b0, 32'h1C, 32'h0);
    #1;
    chk("dw_single_ack", dma_ack, 1'b0);
    chk("dw_readback", cpu_rdata, 32'hA5A5_A5A5);
    cyc();

    // Reset while in DMA_ACC
    cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
    dma_drive(1'b1, 1'b0, 32'h10, 32'h0);
    cyc();
    cpu_req = 1'b1;
    #1;
    chk("rm_acc_stall", cpu_stall, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rm_stall", cpu_stall, 1'b0);
    chk("rm_wr", mem_wr, 1'b0);
    chk("rm_addr", mem_addr, 32'h0);
    chk("rm_rdata", dma_rdata, 32'h0);
    cyc();
    chk("rm_no_ack", dma_ack, 1'b0);
    rst_n = 1'b1;
    dma_drive(1'b0, 1'b0, 32'h0, 32'h0);
    cpu_drive(1'b1, 1'b0, 32'h8, 32'h0);
    cyc();
    chk("rm_post_ack", dma_ack, 1'b0);
    chk("rm_post_stall", cpu_stall, 1'b0);
    chk("rm_post_addr", mem_addr, 32'h8);

    // dma_req drops after two waits: the full four-cycle wait restarts
    dma_drive(1'b1, 1'b0, 32'h10, 32'h0);
    cyc();
    cyc();
    dma_req = 1'b0;
    cyc();
    dma_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("dr_stall%0d", i), cpu_stall, 1'b0);
      cyc();
    end
    #1;
    chk("dr_acc_stall", cpu_stall, 1'b1);
    cyc();
    chk("dr_ack", dma_ack, 1'b1);
    chk("dr_rdata", dma_rdata, 32'hCAFE_BABE);
    dma_drive(1'b0, 1'b0, 32'h0, 32'h0);
    cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
